// File: rtl/seg_display_mux.sv
// seg_display_mux: multiplexed seven-segment driver for a captured result word.
// Shows the word in hex or unsigned decimal (sequential double-dabble), with
// leading-zero blanking, overflow dashes and a one-deep pending-load buffer.
//
// Engine states:
//   state   | meaning
//   IDLE    | no conversion running; a load is handled immediately
//   CONV    | double-dabble running, one input bit per cycle, busy=1
//   DONE    | shadow already holds the result; busy=0; pending/new load starts here
module seg_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  load,
    input  logic                  mode,
    input  logic                  blank_lz,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  busy,
    output logic                  overflow
);

    // Decimal digits needed for 2^DATA_W-1 (floor(DATA_W*log10(2)) + 1).
    localparam int BCD_MIN = ((DATA_W * 1233) >> 12) + 1;
    localparam int BCD_N   = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
    localparam int BCD_W   = 4 * BCD_N;
    localparam int SH_W    = 4 * NUM_DIGITS;
    localparam int HEX_N   = (((DATA_W + 3) / 4) > NUM_DIGITS) ? ((DATA_W + 3) / 4) : NUM_DIGITS;
    localparam int HEX_W   = 4 * HEX_N;
    localparam int CNT_W   = $clog2(DATA_W);
    localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic                  INV      = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = 1;
    localparam logic [6:0]            SEG_DASH = 7'b0000001;
    localparam logic [6:0]            SEG_ZERO = 7'h7E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } eng_state_t;

    eng_state_t          state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   sreg;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W:0]      bcd_sh;
    logic [BCD_W-1:0]    bcd_next;
    logic                dec_ovf;

    logic                pend_valid;
    logic [DATA_W-1:0]   pend_data;
    logic                pend_mode;

    logic                start_req;
    logic [DATA_W-1:0]   start_data;
    logic                start_mode;
    logic [HEX_W-1:0]    start_hex;
    logic                hex_ovf;

    logic [SH_W-1:0]     shadow_dig;
    logic                shadow_ovf;

    logic [REF_W-1:0]    refresh_cnt;
    logic [IDX_W-1:0]    digit_idx;

    logic [3:0]            cur_dig;
    logic [IDX_W-1:0]      msd;
    logic                  dark;
    logic [6:0]            seg_pat;
    logic [NUM_DIGITS-1:0] anode_pat;

    function automatic logic [6:0] font7(input logic [3:0] d);
        case (d)
            4'h0:    return 7'h7E;
            4'h1:    return 7'h30;
            4'h2:    return 7'h6D;
            4'h3:    return 7'h79;
            4'h4:    return 7'h33;
            4'h5:    return 7'h5B;
            4'h6:    return 7'h5F;
            4'h7:    return 7'h70;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h7B;
            4'hA:    return 7'h77;
            4'hB:    return 7'h1F;
            4'hC:    return 7'h4E;
            4'hD:    return 7'h3D;
            4'hE:    return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    // Pick what starts this cycle: a fresh load in IDLE; in DONE the newest of
    // a simultaneous load or the pending entry.
    always_comb begin
        start_req  = 1'b0;
        start_data = data_in;
        start_mode = mode;
        if (state == ST_IDLE) begin
            start_req = load;
        end else if (state == ST_DONE) begin
            if (load) begin
                start_req = 1'b1;
            end else if (pend_valid) begin
                start_req  = 1'b1;
                start_data = pend_data;
                start_mode = pend_mode;
            end
        end
        start_hex = HEX_W'(start_data);
        hex_ovf   = |(start_hex >> SH_W);
    end

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_sh   = {bcd_adj, sreg[DATA_W-1]};
        bcd_next = bcd_sh[BCD_W-1:0];
        dec_ovf  = |(bcd_sh >> SH_W);
    end

    // Conversion engine, pending buffer and shadow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            bcd        <= '0;
            busy       <= 1'b0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_mode  <= 1'b0;
            shadow_dig <= '0;
            shadow_ovf <= 1'b0;
        end else begin
            case (state)
                ST_CONV: begin
                    sreg <= sreg << 1;
                    bcd  <= bcd_next;
                    if (load) begin
                        pend_valid <= 1'b1;
                        pend_data  <= data_in;
                        pend_mode  <= mode;
                    end
                    if (bit_cnt == '0) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        shadow_dig <= bcd_next[SH_W-1:0];
                        shadow_ovf <= dec_ovf;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: begin
                    pend_valid <= 1'b0;
                    if (start_req && start_mode) begin
                        state   <= ST_CONV;
                        busy    <= 1'b1;
                        bit_cnt <= CNT_W'(DATA_W - 1);
                        sreg    <= start_data;
                        bcd     <= '0;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (start_req) begin
                            shadow_dig <= start_hex[SH_W-1:0];
                            shadow_ovf <= hex_ovf;
                        end
                    end
                end
            endcase
        end
    end

    assign overflow = shadow_ovf;

    // Refresh timer and digit scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + 1'b1;
            end
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Segment pattern for the scanned digit: dashes on overflow, dark above the MSD when blanking.
    always_comb begin
        cur_dig = shadow_dig[4*digit_idx +: 4];
        msd     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shadow_dig[4*i +: 4] != 4'd0) begin
                msd = IDX_W'(i);
            end
        end
        dark = blank_lz && (digit_idx > msd);
        if (shadow_ovf) begin
            seg_pat = SEG_DASH;
        end else if (dark) begin
            seg_pat = 7'b0000000;
        end else begin
            seg_pat = font7(cur_dig);
        end
        anode_pat = ONE_HOT0 << digit_idx;
    end

    // Registered display outputs with polarity applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode <= ONE_HOT0 ^ {NUM_DIGITS{INV}};
            seg   <= SEG_ZERO ^ {7{INV}};
        end else begin
            anode <= anode_pat ^ {NUM_DIGITS{INV}};
            seg   <= seg_pat ^ {7{INV}};
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed + random stimulus against a value-level model
// of the display (shadow held as a number and a radix, timed by edge count).
module tb_seg_display_mux;

    localparam int ND = 4;
    localparam int DW = 16;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          load;
    logic          mode;
    logic          blank_lz;
    logic [ND-1:0] anode;
    logic [6:0]    seg;
    logic          busy;
    logic          overflow;

    always #5 clk = ~clk;

    seg_display_mux #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .REFRESH_DIV(RD),
        .ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .load    (load),
        .mode    (mode),
        .blank_lz(blank_lz),
        .anode   (anode),
        .seg     (seg),
        .busy    (busy),
        .overflow(overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] font [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model state: the value the shadow represents and whether it is decimal.
    int     ecnt;
    longint sh_val, sh_prev;
    bit     sh_dec, sh_dec_prev;
    bit     conv_active;
    int     conv_start;
    longint conv_val;
    bit     pend_valid;
    longint pend_val;
    bit     pend_mode;

    function automatic longint pw(longint b, int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic int digit_of(longint v, bit dec, int i);
        if (dec) return int'((v / pw(10, i)) % 10);
        return int'((v >> (4 * i)) & 15);
    endfunction

    function automatic bit ovf_of(longint v, bit dec);
        if (dec) return v >= pw(10, ND);
        return v >= pw(16, ND);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, ecnt, obs, exp);
        end
    endtask

    task automatic start_val(longint v, bit m);
        if (m) begin
            conv_active = 1'b1;
            conv_start  = ecnt;
            conv_val    = v;
        end else begin
            sh_val = v;
            sh_dec = 1'b0;
        end
    endtask

    task automatic model_edge(bit r, bit ld, longint d, bit m);
        if (r) begin
            ecnt        = 0;
            sh_val      = 0;
            sh_dec      = 1'b0;
            sh_prev     = 0;
            sh_dec_prev = 1'b0;
            conv_active = 1'b0;
            pend_valid  = 1'b0;
        end else begin
            ecnt++;
            sh_prev     = sh_val;
            sh_dec_prev = sh_dec;
            if (conv_active && ecnt == conv_start + DW) begin
                sh_val = conv_val;
                sh_dec = 1'b1;
                if (ld) begin pend_valid = 1'b1; pend_val = d; pend_mode = m; end
            end else if (conv_active && ecnt == conv_start + DW + 1) begin
                conv_active = 1'b0;
                if (ld) start_val(d, m);
                else if (pend_valid) start_val(pend_val, pend_mode);
                pend_valid = 1'b0;
            end else if (conv_active) begin
                if (ld) begin pend_valid = 1'b1; pend_val = d; pend_mode = m; end
            end else if (ld) begin
                start_val(d, m);
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check outputs 1 time unit later.
    task automatic cyc(bit r, bit ld, logic [DW-1:0] d, bit m);
        bit            blank_e;
        int            idx, msd;
        int            ed [ND];
        logic [6:0]    pat;
        logic [ND-1:0] exp_an;
        logic [6:0]    exp_seg;
        rst     = r;
        load    = ld;
        data_in = d;
        mode    = m;
        blank_e = blank_lz;
        @(posedge clk);
        model_edge(r, ld, longint'(d), m);
        #1;
        idx = (ecnt == 0) ? 0 : ((ecnt - 1) / RD) % ND;
        msd = 0;
        for (int i = 0; i < ND; i++) begin
            ed[i] = digit_of(sh_prev, sh_dec_prev, i);
            if (ed[i] != 0) msd = i;
        end
        if (ovf_of(sh_prev, sh_dec_prev)) pat = 7'b0000001;
        else if (blank_e && idx > msd)    pat = 7'b0000000;
        else                              pat = font[ed[idx]];
        exp_an  = ~(ND'(1) << idx);
        exp_seg = ~pat;
        check("anode", 32'(anode), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("busy", 32'(busy), 32'(conv_active && ecnt < conv_start + DW));
        check("overflow", 32'(overflow), 32'(ovf_of(sh_val, sh_dec)));
        load = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        mode     = 1'b0;
        data_in  = '0;
        blank_lz = 1'b0;

        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        idle(6);

        // Hex 0xBEEF: digits F,E,E,b, no busy, no overflow.
        cyc(1'b0, 1'b1, 16'hBEEF, 1'b0);
        idle(20);

        // Decimal 1234: busy for 16 cycles, then 4,3,2,1.
        cyc(1'b0, 1'b1, 16'd1234, 1'b1);
        idle(24);

        // Decimal 12345: overflow, all dashes.
        cyc(1'b0, 1'b1, 16'd12345, 1'b1);
        idle(24);

        // Blanking: 0x0042 then 0.
        blank_lz = 1'b1;
        cyc(1'b0, 1'b1, 16'h0042, 1'b0);
        idle(18);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        idle(18);
        blank_lz = 1'b0;
        idle(2);

        // Pending: 100 decimal, then 7 and 99 while busy; 99 wins.
        cyc(1'b0, 1'b1, 16'd100, 1'b1);
        idle(2);
        cyc(1'b0, 1'b1, 16'd7, 1'b1);
        idle(4);
        cyc(1'b0, 1'b1, 16'd99, 1'b1);
        idle(40);

        // Pending hex entry held until DONE; load landing exactly on DONE.
        cyc(1'b0, 1'b1, 16'd5, 1'b1);
        idle(3);
        cyc(1'b0, 1'b1, 16'h00A7, 1'b0);
        idle(20);
        cyc(1'b0, 1'b1, 16'd321, 1'b1);
        idle(16);
        cyc(1'b0, 1'b1, 16'd4321, 1'b1);
        idle(24);

        // Reset mid-conversion: 5000 decimal, reset 8 cycles later.
        cyc(1'b0, 1'b1, 16'd5000, 1'b1);
        idle(7);
        cyc(1'b1, 1'b0, '0, 1'b0);
        idle(30);

        // Randomised loads, radices, blanking and occasional resets.
        for (int n = 0; n < 600; n++) begin
            bit            r, ld, m;
            logic [DW-1:0] d;
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 5) == 0);
            m  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       d = DW'($urandom_range(0, 9999));
                1:       d = DW'($urandom_range(0, 300));
                default: d = DW'($urandom);
            endcase
            cyc(r, ld, d, m);
        end
        idle(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
